// File: rtl/seven_segment_display_scanner_pkg.sv
// Shared types and constants for the seven-segment scanner and its
// serial binary-to-BCD converter.
package seven_segment_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_COMMIT  = 2'd2
   } scan_state_e;

   localparam bcd_digit_t BCD_ADJUST           = 4'd3;
   localparam bcd_digit_t BCD_ADJUST_THRESHOLD = 4'd5;

   // 10**n, used to size the overflow limit at elaboration time
   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned p;
      p = 64'd1;
      for (int unsigned i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

endpackage

// File: rtl/seven_segment_display_scanner_binary_to_bcd_serial.sv
// Serial double-dabble converter: accepts one binary value per handshake and
// presents packed BCD plus an overflow flag with a one-cycle done strobe.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | ready for a value; load shift register on handshake
//   S_CONVERT | VALUE_WIDTH adjust-and-shift iterations
//   S_COMMIT  | done strobe; BCD and overflow valid for one cycle
module binary_to_bcd_serial
   import seven_segment_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int VALUE_WIDTH = 14
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [VALUE_WIDTH-1:0] value,
   input  logic                   value_valid,
   output logic                   value_ready,
   output logic                   done,
   output logic [4*DIGITS-1:0]    bcd_digits,
   output logic                   overflow
);

   localparam int              SR_W      = 4*DIGITS + VALUE_WIDTH;
   localparam int              CNT_W     = $clog2(VALUE_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VALUE_WIDTH - 1);
   localparam longint unsigned OVF_LIMIT = pow10(DIGITS);

   scan_state_e      state;
   scan_state_e      state_nxt;
   logic [SR_W-1:0]  shreg;
   logic [SR_W-1:0]  shreg_adj;
   logic [CNT_W-1:0] cnt;
   logic             ovf_q;
   logic             accept;

   assign accept = value_valid && value_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (value_valid)     state_nxt = S_CONVERT;
         S_CONVERT: if (cnt == CNT_LAST) state_nxt = S_COMMIT;
         S_COMMIT:                       state_nxt = S_IDLE;
         default:                        state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      value_ready = (state == S_IDLE);
      done        = (state == S_COMMIT);
   end

   // add 3 to every BCD nibble that will reach 10 or more after the shift
   always_comb begin
      shreg_adj = shreg;
      for (int i = 0; i < DIGITS; i++) begin
         if (shreg[VALUE_WIDTH + 4*i +: 4] >= BCD_ADJUST_THRESHOLD) begin
            shreg_adj[VALUE_WIDTH + 4*i +: 4] = shreg[VALUE_WIDTH + 4*i +: 4] + BCD_ADJUST;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg <= '0;
         cnt   <= '0;
         ovf_q <= 1'b0;
      end else if (accept) begin
         shreg <= SR_W'(value);
         cnt   <= '0;
         ovf_q <= (64'(value) >= OVF_LIMIT);
      end else if (state == S_CONVERT) begin
         shreg <= shreg_adj << 1;
         cnt   <= cnt + CNT_W'(1);
      end
   end

   assign bcd_digits = shreg[SR_W-1 -: 4*DIGITS];
   assign overflow   = ovf_q;

endmodule

// File: rtl/seven_segment_display_scanner.sv
// Multiplexed seven-segment driver: converts an accepted binary value to BCD
// and scans the committed digits one at a time with leading-zero blanking.
module seven_segment_display_scanner
   import seven_segment_pkg::*;
#(
   parameter int DIGITS              = 4,
   parameter int VALUE_WIDTH         = 14,
   parameter int SCAN_DIVIDE         = 50000,
   parameter int BLANK_LEADING_ZEROS = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [VALUE_WIDTH-1:0] value,
   input  logic                   value_valid,
   output logic                   value_ready,
   output logic [3:0]             bcd,
   output logic                   bcd_valid,
   output logic [DIGITS-1:0]      digit_select,
   output logic                   overflow
);

   localparam int               PRE_W    = (SCAN_DIVIDE > 1) ? $clog2(SCAN_DIVIDE) : 1;
   localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIVIDE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic                conv_done;
   logic [4*DIGITS-1:0] conv_bcd;
   logic                conv_ovf;

   logic [4*DIGITS-1:0] disp_bcd;
   logic                disp_ovf;
   logic [PRE_W-1:0]    pre_cnt;
   logic [IDX_W-1:0]    idx;
   logic [DIGITS-1:0]   upper_zero;
   bcd_digit_t          sel_digit;
   logic                sel_blank;

   binary_to_bcd_serial #(
      .DIGITS      (DIGITS),
      .VALUE_WIDTH (VALUE_WIDTH)
   ) u_conv (
      .clk         (clk),
      .rst_n       (rst_n),
      .value       (value),
      .value_valid (value_valid),
      .value_ready (value_ready),
      .done        (conv_done),
      .bcd_digits  (conv_bcd),
      .overflow    (conv_ovf)
   );

   // display register only moves on the converter's done strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_bcd <= '0;
         disp_ovf <= 1'b0;
      end else if (conv_done) begin
         disp_bcd <= conv_bcd;
         disp_ovf <= conv_ovf;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         idx     <= '0;
      end else if (pre_cnt == PRE_LAST) begin
         pre_cnt <= '0;
         idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   // upper_zero[i]: digit i and every digit above it are zero
   always_comb begin
      upper_zero = '0;
      upper_zero[DIGITS-1] = (disp_bcd[4*DIGITS-1 -: 4] == 4'd0);
      for (int i = DIGITS-2; i >= 0; i--) begin
         upper_zero[i] = (disp_bcd[4*i +: 4] == 4'd0) && upper_zero[i+1];
      end
   end

   always_comb begin
      sel_digit = '0;
      sel_blank = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            sel_digit = disp_bcd[4*i +: 4];
            sel_blank = (BLANK_LEADING_ZEROS != 0) && (i != 0) && upper_zero[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd          <= '0;
         bcd_valid    <= 1'b0;
         digit_select <= DIGITS'(1);
      end else begin
         digit_select <= DIGITS'(1) << idx;
         if (disp_ovf) begin
            bcd       <= '0;
            bcd_valid <= 1'b0;
         end else begin
            bcd       <= sel_digit;
            bcd_valid <= !sel_blank;
         end
      end
   end

   assign overflow = disp_ovf;

endmodule

// File: tb/tb_seven_segment_display_scanner.sv
// Directed self-checking bench for seven_segment_display_scanner with a
// short scan period so every digit position is visited quickly.
module tb_seven_segment_display_scanner;

   logic        clk;
   logic        rst_n;
   logic [13:0] value;
   logic        value_valid;
   logic        value_ready;
   logic [3:0]  bcd;
   logic        bcd_valid;
   logic [3:0]  digit_select;
   logic        overflow;

   int n_assert = 0;
   int n_fail   = 0;

   seven_segment_display_scanner #(
      .DIGITS              (4),
      .VALUE_WIDTH         (14),
      .SCAN_DIVIDE         (4),
      .BLANK_LEADING_ZEROS (1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .value        (value),
      .value_valid  (value_valid),
      .value_ready  (value_ready),
      .bcd          (bcd),
      .bcd_valid    (bcd_valid),
      .digit_select (digit_select),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // offer one value, then count cycles with value_ready low
   task automatic send(input logic [13:0] v, output int low_cycles);
      int guard;
      guard = 0;
      while (value_ready !== 1'b1 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      value       = v;
      value_valid = 1'b1;
      @(posedge clk);
      #1 value_valid = 1'b0;
      low_cycles = 0;
      @(negedge clk);
      while (value_ready !== 1'b1 && low_cycles < 40) begin
         low_cycles++;
         @(negedge clk);
      end
   endtask

   task automatic check_scan(input logic [15:0] exp_bcd, input logic [3:0] exp_valid, input string tag);
      int guard;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 4; d++) begin
         guard = 0;
         while (digit_select !== 4'(1 << d) && guard < 24) begin
            @(negedge clk);
            guard++;
         end
         chk($sformatf("%s_sel%0d", tag, d), 32'(digit_select), 32'(1 << d));
         chk($sformatf("%s_bcd%0d", tag, d), 32'(bcd), 32'(exp_bcd[4*d +: 4]));
         chk($sformatf("%s_valid%0d", tag, d), 32'(bcd_valid), 32'(exp_valid[d]));
      end
   endtask

   initial begin
      int          lc;
      int          accept_m;
      int          seen8;
      int          sel_d;
      logic [15:0] hs_bcd;
      logic [3:0]  hs_val;

      rst_n       = 1'b0;
      value       = '0;
      value_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(value_ready), 32'd1);
      chk("rst_bcd", 32'(bcd), 32'd0);
      chk("rst_valid", 32'(bcd_valid), 32'd0);
      chk("rst_sel", 32'(digit_select), 32'd1);
      chk("rst_ovf", 32'(overflow), 32'd0);

      rst_n = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         chk($sformatf("post_rst_sel_k%0d", k), 32'(digit_select), 32'(1 << (((k-1)/4) % 4)));
         chk($sformatf("post_rst_valid_k%0d", k), 32'(bcd_valid), 32'((((k-1)/4) % 4) == 0));
         chk($sformatf("post_rst_bcd_k%0d", k), 32'(bcd), 32'd0);
      end

      send(14'd1234, lc);
      chk("conv1234_ready_low", 32'(lc), 32'd15);
      check_scan(16'h1234, 4'b1111, "v1234");

      send(14'd7, lc);
      check_scan(16'h0007, 4'b0001, "v7");
      send(14'd1005, lc);
      check_scan(16'h1005, 4'b1111, "v1005");
      send(14'd0, lc);
      check_scan(16'h0000, 4'b0001, "v0");

      send(14'd9999, lc);
      chk("v9999_ovf", 32'(overflow), 32'd0);
      check_scan(16'h9999, 4'b1111, "v9999");
      send(14'd10000, lc);
      chk("v10000_ovf", 32'(overflow), 32'd1);
      check_scan(16'h0000, 4'b0000, "v10000");
      send(14'd42, lc);
      chk("v42_ovf", 32'(overflow), 32'd0);
      check_scan(16'h0042, 4'b0011, "v42");

      // valid held high; value changes while the first conversion runs
      hs_bcd      = 16'h0300;
      hs_val      = 4'b0111;
      value       = 14'd300;
      value_valid = 1'b1;
      @(posedge clk);
      #1 value = 14'd500;
      accept_m = -1;
      for (int m = 0; m < 32; m++) begin
         @(negedge clk);
         if (m >= 16) begin
            sel_d = -1;
            for (int d = 0; d < 4; d++) if (digit_select === 4'(1 << d)) sel_d = d;
            chk($sformatf("hs_sel_m%0d", m), 32'($onehot(digit_select)), 32'd1);
            if (sel_d >= 0) begin
               chk($sformatf("hs_bcd_m%0d", m), 32'(bcd), 32'(hs_bcd[4*sel_d +: 4]));
               chk($sformatf("hs_valid_m%0d", m), 32'(bcd_valid), 32'(hs_val[sel_d]));
            end
         end
         if (value_ready === 1'b1 && value_valid === 1'b1 && accept_m < 0) begin
            accept_m = m;
            value    = 14'd21;
         end
         if (m == 16) value_valid = 1'b0;
      end
      chk("hs_b2b_gap", 32'(accept_m + 1), 32'd16);
      check_scan(16'h0021, 4'b0011, "v21");

      send(14'd42, lc);
      check_scan(16'h0042, 4'b0011, "v42b");
      value       = 14'd8888;
      value_valid = 1'b1;
      @(posedge clk);
      #1 value_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_ready", 32'(value_ready), 32'd1);
      chk("midrst_ovf", 32'(overflow), 32'd0);
      seen8 = 0;
      for (int m = 0; m < 40; m++) begin
         @(negedge clk);
         if (bcd_valid === 1'b1 && bcd === 4'd8) seen8++;
      end
      chk("midrst_no_8888", 32'(seen8), 32'd0);
      check_scan(16'h0000, 4'b0001, "midrst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/seven_segment_display_scanner.md
# seven_segment_display_scanner

Upstream driver for the multiplexed seven-segment display. It accepts a binary value over a valid/ready handshake and converts it to packed BCD with a serial double-dabble engine. It then time-multiplexes the digits, one at a time, into the per-digit BCD-to-segment converter, which consumes `bcd` and `bcd_valid` and drives the segment lines. `digit_select` drives the digit enables.

## Interface
- `DIGITS`, 4: number of display digits, ≥1.
- `VALUE_WIDTH`, 14: binary input width; must satisfy 2**VALUE_WIDTH ≥ 10**DIGITS.
- `SCAN_DIVIDE`, 50000: clock cycles each digit is held, ≥2.
- `BLANK_LEADING_ZEROS`, 1: when 1, suppress leading zeros.

- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `value`  in  VALUE_WIDTH: unsigned binary to display.
- `value_valid`  in  1: `value` offered.
- `value_ready`  out  1: block can accept; transfer when valid & ready.
- `bcd`  out  4: BCD digit for the currently selected position.
- `bcd_valid`  out  1: 0 = blank this digit.
- `digit_select`  out  DIGITS: one-hot active-high enable; bit 0 = least significant digit.
- `overflow`  out  1: last accepted value ≥ 10**DIGITS.

## Operation
- **FSM states:** IDLE, CONVERT, COMMIT.
  - IDLE: `value_ready`=1. On handshake, load the shift register and clear the cycle counter. Evaluate overflow as `value` ≥ 10**DIGITS, computed as a localparam. Go to CONVERT.
  - CONVERT: runs exactly VALUE_WIDTH cycles. Each cycle, every BCD nibble ≥5 gets +3, then the whole register shifts left by 1. Shift register width is 4*DIGITS+VALUE_WIDTH. Go to COMMIT.
  - COMMIT: write the BCD nibbles and the overflow flag into the display register in a single cycle. Go to IDLE.
- **Display register:** changes only in COMMIT, so scanning never shows a half-converted value.
- **Scanning:** runs continuously and independently of the FSM.
  - A prescaler counts 0..SCAN_DIVIDE-1.
  - At terminal count, the digit index advances 0→DIGITS-1 and wraps to 0.
- **Registered outputs:** `bcd`, `bcd_valid` and `digit_select` are registered from the current index and the display register.
- **`bcd_valid` rules:**
  - 0 if overflow is set; on overflow, all digits are blank and `bcd`=0.
  - 0 if BLANK_LEADING_ZEROS=1, the digit is 0, and every higher digit is 0.
  - Digit 0 is never blanked by the leading-zero rule.
  - Interior zeros are always shown.

## Timing
- **Reset values:** `value_ready`=1, `bcd`=0, `bcd_valid`=0, `digit_select`=1, `overflow`=0, FSM=IDLE, prescaler=0, index=0, display register=0.
- **After reset release:**
  - First rising edge: `bcd`=0, `bcd_valid`=1 on digit 0, so the display shows "0".
  - Each digit is then held SCAN_DIVIDE cycles.
- **Conversion latency:**
  - Handshake at edge N.
  - `value_ready` is low for edges N+1 .. N+VALUE_WIDTH+1.
  - Display register is updated at edge N+VALUE_WIDTH+1.
  - The new digit appears on outputs one edge later.
  - `value_ready` rises again at edge N+VALUE_WIDTH+2.
- **Back-to-back values:** `value_valid` held high with new data gives one accept every VALUE_WIDTH+2 cycles. `value` is sampled only at handshake, so later changes to `value` have no effect on a conversion already in progress.
- **Commit coinciding with a digit advance:** the new index reads the new register contents.
- **Reset mid-conversion:** aborts the conversion and returns to reset state; the display reverts to "0".

## Structure
- **Package `seven_segment_pkg`:**
  - typedef `bcd_digit_t` (logic [3:0]).
  - FSM state enum `scan_state_e`.
  - Constant `BCD_ADJUST` = 4'd3.
  - Constant `BCD_ADJUST_THRESHOLD` = 4'd5.
- **Sub-module `binary_to_bcd_serial`:** holds the double-dabble FSM, shift register and `value` handshake. It presents a one-cycle `done` strobe with the parallel BCD and overflow flag.
- **Top level:** display register, prescaler, digit index, blanking logic and output registers.

## Test plan
Bench parameters: DIGITS=4, VALUE_WIDTH=14, SCAN_DIVIDE=4.

- **Reset:** hold `rst_n`=0 → outputs equal their reset values. Release → digit 0: `bcd`=0, `bcd_valid`=1. Digits 1–3: `bcd_valid`=0. Each digit is held 4 cycles and `digit_select` cycles 1,2,4,8,1.
- **Conversion of 1234:** `value_ready` is low for exactly 15 cycles. The scan then shows `bcd` 4,3,2,1 on digits 0..3, all valid.
- **Blanking:**
  - Value 7 → only digit 0 valid, `bcd`=7.
  - Value 1005 → all valid, digits 5,0,0,1.
  - Value 0 → digit 0 valid with `bcd`=0.
- **Overflow:**
  - Value 9999 → 9,9,9,9, `overflow`=0.
  - Then 10000 → `overflow`=1, all digits `bcd_valid`=0.
  - Then 42 → `overflow`=0, display shows 42.
- **Handshake:** `value_valid` held high and `value` changed during CONVERT → no second accept until `value_ready`=1. The display shows the originally sampled value; a back-to-back accept occurs 16 cycles after the first.
- **Reset mid-conversion:** pulse `rst_n` low 5 cycles into converting 8888 → display shows "0" and 8888 never appears.
